// File: rtl/msg_bus_sequencer.sv
// msg_bus_sequencer: WISHBONE master that drains the PACKET2MESSAGE queue.
// Arbitrates for the bus, runs a burst_lenght-beat cycle, and reports
// per-beat advance, retry or completion back to the queue. A per-beat
// timeout, a back-off between attempts and a retry limit bound the time
// spent on a message; a message that hits the limit or sees ERR is dropped.
module msg_bus_sequencer #(
   parameter int N_BITS_BURST_LENGHT = 7,
   parameter int TIMEOUT_CYCLES      = 16,
   parameter int BACKOFF_CYCLES      = 4,
   parameter int MAX_RETRY           = 8,
   parameter int N_BITS_CNT          = 5,
   parameter int BUS_ADDRESS_WIDTH   = 32,
   parameter int BUS_DATA_WIDTH      = 32,
   parameter int BUS_SEL_WIDTH       = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           r_bus_arbitration_i,
   input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
   input  logic [BUS_DATA_WIDTH-1:0]      data_i,
   input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
   input  logic                           transaction_type_i,
   input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
   output logic                           next_data_o,
   output logic                           retry_o,
   output logic                           message_transmitted_o,
   output logic                           bus_req_o,
   input  logic                           bus_gnt_i,
   output logic                           cyc_o,
   output logic                           stb_o,
   output logic                           we_o,
   output logic [BUS_ADDRESS_WIDTH-1:0]   adr_o,
   output logic [BUS_DATA_WIDTH-1:0]      dat_o,
   output logic [BUS_SEL_WIDTH-1:0]       sel_o,
   input  logic                           ack_i,
   input  logic                           rty_i,
   input  logic                           err_i,
   output logic                           drop_o
);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_BACKOFF} state_e;

   localparam logic [N_BITS_CNT-1:0]          CNT_ONE  = N_BITS_CNT'(1);
   localparam logic [N_BITS_CNT-1:0]          CNT_SAT  = '1;
   localparam logic [N_BITS_CNT-1:0]          TMO_LAST = N_BITS_CNT'(TIMEOUT_CYCLES - 1);
   localparam logic [N_BITS_CNT-1:0]          BO_LAST  = N_BITS_CNT'(BACKOFF_CYCLES - 1);
   localparam logic [N_BITS_CNT-1:0]          RTY_MAX  = N_BITS_CNT'(MAX_RETRY);
   localparam logic [N_BITS_BURST_LENGHT-1:0] BEAT_ONE = N_BITS_BURST_LENGHT'(1);

   state_e                         state_q;
   logic [N_BITS_BURST_LENGHT-1:0] beat_q;
   logic [N_BITS_CNT-1:0]          tmo_q;
   logic [N_BITS_CNT-1:0]          bo_q;
   logic [N_BITS_CNT-1:0]          rcnt_q;
   logic [N_BITS_CNT-1:0]          rcnt_d;

   logic tmo_hit;
   logic ack_last;
   logic rty_ev;
   logic rty_limit;

   // Beat response classification; losing the grant counts as a retry
   always_comb begin
      rcnt_d    = (rcnt_q == CNT_SAT) ? rcnt_q : rcnt_q + CNT_ONE;
      tmo_hit   = (tmo_q == TMO_LAST);
      ack_last  = (beat_q == burst_lenght_i - BEAT_ONE);
      rty_ev    = rty_i | tmo_hit | ~bus_gnt_i;
      rty_limit = (rcnt_d == RTY_MAX);
   end

   // Queue strobes and drop, one cycle wide, priority ERR > RTY/timeout > ACK
   always_comb begin
      next_data_o           = 1'b0;
      retry_o               = 1'b0;
      message_transmitted_o = 1'b0;
      drop_o                = 1'b0;
      if (state_q == S_XFER) begin
         if (err_i) begin
            message_transmitted_o = 1'b1;
            drop_o                = 1'b1;
         end else if (rty_ev) begin
            if (rty_limit) begin
               message_transmitted_o = 1'b1;
               drop_o                = 1'b1;
            end else begin
               retry_o = 1'b1;
            end
         end else if (ack_i) begin
            if (ack_last) message_transmitted_o = 1'b1;
            else          next_data_o           = 1'b1;
         end
      end
   end

   // Bus side decoded from state; queue fields pass through only while CYC is up
   always_comb begin
      cyc_o     = (state_q == S_XFER);
      stb_o     = (state_q == S_XFER);
      bus_req_o = (state_q == S_XFER) || (state_q == S_ARB);
      we_o      = cyc_o ? transaction_type_i : 1'b0;
      adr_o     = cyc_o ? address_i : '0;
      dat_o     = cyc_o ? data_i    : '0;
      sel_o     = cyc_o ? sel_i     : '0;
   end

   // Sequencer FSM with beat, timeout, back-off and retry counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         tmo_q   <= '0;
         bo_q    <= '0;
         rcnt_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (r_bus_arbitration_i) state_q <= S_ARB;
            end
            S_ARB: begin
               if (bus_gnt_i) begin
                  state_q <= S_XFER;
                  beat_q  <= '0;
                  tmo_q   <= '0;
               end
            end
            S_XFER: begin
               if (err_i) begin
                  rcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else if (rty_ev) begin
                  if (rty_limit) begin
                     rcnt_q  <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     rcnt_q  <= rcnt_d;
                     bo_q    <= '0;
                     state_q <= S_BACKOFF;
                  end
               end else if (ack_i) begin
                  if (ack_last) begin
                     rcnt_q  <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     beat_q <= beat_q + BEAT_ONE;
                     tmo_q  <= '0;
                  end
               end else if (tmo_q != CNT_SAT) begin
                  tmo_q <= tmo_q + CNT_ONE;
               end
            end
            S_BACKOFF: begin
               if (bo_q >= BO_LAST) begin
                  bo_q    <= '0;
                  state_q <= S_ARB;
               end else begin
                  bo_q <= bo_q + CNT_ONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
